inst_fetch_unit: RTL and testbench

Front-end fetch stage that consumes the PC stream from the PC generator and issues one instruction-memory read at a time. It pairs each returned instruction word with its PC and buffers them in a small FIFO for predecode/decode. It drives `PcStop` back to the control path so the PC generator holds while a fetch is in flight or the buffer is full. It also squashes in-flight and buffered work on any pipeline flush or redirect.

---
 rtl/inst_fetch_unit_pkg.sv | 22 ++
 rtl/inst_fetch_unit_fetch_fifo.sv | 57 +++++
 rtl/inst_fetch_unit.sv | 87 ++++++++
 tb/tb_inst_fetch_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-path defines: bus widths, reset PC, FSM encodings, buffer entry layout.
package inst_fetch_unit_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  // PC held in the latched-PC registers out of reset.
  localparam logic [InstAddrBus-1:0] _Entry = 32'h1C00_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDrop = 2'd3
  } fetchState_e;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } ibufEntry_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO with synchronous flush and async active-low reset.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic             Flush,
  input  logic             PushValid,
  input  logic [WIDTH-1:0] PushData,
  input  logic             PopReady,
  output logic             Full,
  output logic             HeadValid,
  output logic [WIDTH-1:0] HeadData
);

  localparam int PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]             wrPtr, rdPtr;
  logic [PtrW:0]               count;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        push, pop;

  assign Full      = (count == (PtrW+1)'(DEPTH));
  assign HeadValid = (count != '0);
  // Head reads as zero when empty so the outputs are clean after reset/flush.
  assign HeadData  = HeadValid ? mem[rdPtr] : '0;
  assign push      = PushValid && !Full;
  assign pop       = PopReady && HeadValid;

  // Pointer/count bookkeeping; flush wins over any push or pop in the same cycle.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (Flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only meaningful where count says so.
  always_ff @(posedge Clk) begin
    if (push && !Flush) mem[wrPtr] <= PushData;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: one outstanding I-mem read, pairs response with its PC, buffers for decode.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                     DEPTH = 4,
  parameter logic [InstAddrBus-1:0] ENTRY = _Entry
) (
  input  logic                   Clk,
  input  logic                   Rest,
  input  logic                   PcAble,
  input  logic [InstAddrBus-1:0] PcDate,
  input  logic                   FetchFlush,
  output logic                   PcStop,
  output logic                   MemReqValid,
  output logic [InstAddrBus-1:0] MemReqAddr,
  input  logic                   MemReqReady,
  input  logic                   MemRespValid,
  input  logic [InstBus-1:0]     MemRespData,
  output logic                   IbufValid,
  output logic [InstAddrBus-1:0] IbufPc,
  output logic [InstBus-1:0]     IbufInst,
  input  logic                   IbufReady
);

  fetchState_e            state, stateNext;
  logic [InstAddrBus-1:0] ReqPc;
  logic                   full, accept, pushValid;
  ibufEntry_t             pushEntry, headEntry;

  assign accept      = (state == StIdle) && PcAble && !full && !FetchFlush;
  assign MemReqValid = (state == StReq);
  // PC generator only produces word-aligned PCs, so the latched PC goes out as is.
  assign MemReqAddr  = ReqPc;
  assign PcStop      = (state != StIdle) || full;
  // A response is kept only in WAIT and only if no flush lands with it.
  assign pushValid   = (state == StWait) && MemRespValid && !FetchFlush;
  assign pushEntry   = '{pc: ReqPc, inst: MemRespData};

  // State register.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) state <= StIdle;
    else       state <= stateNext;
  end

  // Latch the PC on accept; it stays put through REQ/WAIT so the push pairs correctly.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest)       ReqPc <= ENTRY;
    else if (accept) ReqPc <= PcDate;
  end

  // Next-state: a request already handed to memory must have its response drained (DROP).
  always_comb begin
    stateNext = state;
    case (state)
      StIdle: if (accept) stateNext = StReq;
      StReq: begin
        if (MemReqReady)     stateNext = FetchFlush ? StDrop : StWait;
        else if (FetchFlush) stateNext = StIdle;
      end
      StWait: begin
        if (MemRespValid)    stateNext = StIdle;
        else if (FetchFlush) stateNext = StDrop;
      end
      StDrop: if (MemRespValid) stateNext = StIdle;
      default: stateNext = StIdle;
    endcase
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(ibufEntry_t))
  ) uFifo (
    .Clk      (Clk),
    .Rest     (Rest),
    .Flush    (FetchFlush),
    .PushValid(pushValid),
    .PushData (pushEntry),
    .PopReady (IbufReady),
    .Full     (full),
    .HeadValid(IbufValid),
    .HeadData (headEntry)
  );

  assign IbufPc   = headEntry.pc;
  assign IbufInst = headEntry.inst;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; memory handshakes are driven by hand.
module tb_inst_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rest, PcAble, FetchFlush, MemReqReady, MemRespValid, IbufReady;
  logic [31:0] PcDate, MemRespData;
  logic        PcStop, MemReqValid, IbufValid;
  logic [31:0] MemReqAddr, IbufPc, IbufInst;

  int nCmp = 0;
  int nBad = 0;

  always #5 Clk = ~Clk;

  inst_fetch_unit #(.DEPTH(4)) dut (
    .Clk(Clk), .Rest(Rest), .PcAble(PcAble), .PcDate(PcDate), .FetchFlush(FetchFlush),
    .PcStop(PcStop), .MemReqValid(MemReqValid), .MemReqAddr(MemReqAddr),
    .MemReqReady(MemReqReady), .MemRespValid(MemRespValid), .MemRespData(MemRespData),
    .IbufValid(IbufValid), .IbufPc(IbufPc), .IbufInst(IbufInst), .IbufReady(IbufReady)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Full fetch at best-case timing: accept, ready next cycle, response the cycle after.
  task automatic fetchOne(input logic [31:0] pc, input logic [31:0] inst, input bit popAtResp);
    PcAble = 1'b1; PcDate = pc;
    step();
    PcAble = 1'b0;
    chk("reqValid", MemReqValid, 1);
    chk("reqAddr", MemReqAddr, pc);
    chk("reqStop", PcStop, 1);
    MemReqReady = 1'b1;
    step();
    MemReqReady = 1'b0;
    chk("waitNoReq", MemReqValid, 0);
    chk("waitStop", PcStop, 1);
    MemRespValid = 1'b1; MemRespData = inst; IbufReady = popAtResp;
    step();
    MemRespValid = 1'b0; IbufReady = 1'b0;
  endtask

  task automatic popChk(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "Valid"}, IbufValid, 1);
    chk({tag, "Pc"}, IbufPc, pc);
    chk({tag, "Inst"}, IbufInst, inst);
    IbufReady = 1'b1;
    step();
    IbufReady = 1'b0;
  endtask

  initial begin
    Rest = 1'b0; PcAble = 1'b0; FetchFlush = 1'b0; MemReqReady = 1'b0;
    MemRespValid = 1'b0; IbufReady = 1'b0; PcDate = '0; MemRespData = '0;
    step(); step();
    chk("rstIbufValid", IbufValid, 0);
    chk("rstIbufPc", IbufPc, 0);
    chk("rstIbufInst", IbufInst, 0);
    chk("rstPcStop", PcStop, 0);
    chk("rstReqValid", MemReqValid, 0);
    Rest = 1'b1;
    step();

    // Single fetch; entry is left in the buffer for the reset test.
    fetchOne(32'h1C00_0000, 32'h0280_0000, 1'b0);
    chk("oneValid", IbufValid, 1);
    chk("onePc", IbufPc, 32'h1C00_0000);
    chk("oneInst", IbufInst, 32'h0280_0000);
    chk("oneStop", PcStop, 0);

    // Reset while in WAIT aborts the fetch and empties the buffer.
    PcAble = 1'b1; PcDate = 32'h1C00_0004;
    step();
    PcAble = 1'b0; MemReqReady = 1'b1;
    step();
    MemReqReady = 1'b0;
    chk("midWaitStop", PcStop, 1);
    Rest = 1'b0;
    #1;
    chk("asyncRstStop", PcStop, 0);
    chk("asyncRstIbuf", IbufValid, 0);
    step();
    Rest = 1'b1;
    MemRespValid = 1'b1; MemRespData = 32'hDEAD_BEEF;
    step();
    MemRespValid = 1'b0;
    chk("staleRespIbuf", IbufValid, 0);
    chk("staleRespStop", PcStop, 0);
    chk("staleRespReq", MemReqValid, 0);

    // Fill the buffer with decode stalled.
    for (int i = 0; i < 4; i++) begin
      fetchOne(32'h1C00_0100 + 32'(4 * i), 32'h0000_0100 + 32'(i), 1'b0);
      chk("fillStop", PcStop, (i == 3) ? 32'd1 : 32'd0);
    end
    PcAble = 1'b1; PcDate = 32'h1C00_0500;
    step();
    chk("fullNoReq", MemReqValid, 0);
    chk("fullStop", PcStop, 1);
    chk("fullHeadPc", IbufPc, 32'h1C00_0100);
    IbufReady = 1'b1;
    step();
    IbufReady = 1'b0; PcAble = 1'b0;
    chk("popStopDrop", PcStop, 0);
    chk("popNoReq", MemReqValid, 0);

    // Count 3: push and pop on the same edge keep the count and the order.
    fetchOne(32'h1C00_0200, 32'h0000_0200, 1'b1);
    popChk("ord0", 32'h1C00_0108, 32'h0000_0102);
    popChk("ord1", 32'h1C00_010C, 32'h0000_0103);
    popChk("ord2", 32'h1C00_0200, 32'h0000_0200);
    chk("ordEmpty", IbufValid, 0);

    // Flush in WAIT with a buffered entry: response dropped, buffer emptied.
    fetchOne(32'h1C00_0300, 32'h0000_0300, 1'b0);
    PcAble = 1'b1; PcDate = 32'h1C00_0304;
    step();
    PcAble = 1'b0; MemReqReady = 1'b1;
    step();
    MemReqReady = 1'b0; FetchFlush = 1'b1;
    step();
    FetchFlush = 1'b0;
    chk("dropStop0", PcStop, 1);
    chk("dropIbuf", IbufValid, 0);
    step();
    chk("dropStop1", PcStop, 1);
    MemRespValid = 1'b1; MemRespData = 32'h0000_0304;
    step();
    MemRespValid = 1'b0;
    chk("dropDoneStop", PcStop, 0);
    chk("dropDoneIbuf", IbufValid, 0);

    // Flush with handshake in the same REQ cycle still drains the response.
    PcAble = 1'b1; PcDate = 32'h1C00_0400;
    step();
    PcAble = 1'b0; MemReqReady = 1'b1; FetchFlush = 1'b1;
    step();
    MemReqReady = 1'b0; FetchFlush = 1'b0;
    chk("hsFlushStop", PcStop, 1);
    chk("hsFlushReq", MemReqValid, 0);
    MemRespValid = 1'b1; MemRespData = 32'h0000_0400;
    step();
    MemRespValid = 1'b0;
    chk("hsFlushDone", PcStop, 0);
    chk("hsFlushIbuf", IbufValid, 0);

    // Flush in REQ without ready: request withdrawn, then a normal fetch.
    PcAble = 1'b1; PcDate = 32'h1C00_0080;
    step();
    PcAble = 1'b0;
    chk("reqFlushPre", MemReqValid, 1);
    FetchFlush = 1'b1;
    step();
    FetchFlush = 1'b0;
    chk("reqFlushReq", MemReqValid, 0);
    chk("reqFlushStop", PcStop, 0);
    fetchOne(32'h1C00_0040, 32'h1234_5678, 1'b0);
    popChk("refetch", 32'h1C00_0040, 32'h1234_5678);

    // Ten fetches walk the pointers around several times.
    for (int i = 0; i < 10; i++) begin
      fetchOne(32'h1C00_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
      popChk("wrap", 32'h1C00_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    end
    chk("wrapEmpty", IbufValid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
